alu_sequencer: RTL and testbench

//  Execute stage between operand registers A/B and output register O. Samples A/B operands on start.

---
 rtl/alu_sequencer.sv | 99 +++++++++
 tb/tb_alu_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: execute stage doing single-cycle ADD/SUB and shift-add unsigned MUL,
// with an O-register load strobe and status flags.
module alu_sequencer #(
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [INPUT_WIDTH-1:0]  a_in,
    input  logic [INPUT_WIDTH-1:0]  b_in,
    output logic                    busy,
    output logic                    done,
    output logic                    ldo,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic                    carry,
    output logic                    zero,
    output logic                    err
);
    localparam int IW = INPUT_WIDTH;
    localparam int OW = OUTPUT_WIDTH;
    localparam int CW = $clog2(IW + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] a_r;
    logic [OW:0]   p;
    logic [CW-1:0] count;
    logic [IW:0]   sum;
    logic [OW:0]   p_next;
    logic [OW-1:0] add_res;
    logic [OW-1:0] sub_res;

    // Upper IW+1 bits of p form the accumulator, so the add carry never escapes.
    always_comb begin
        sum     = p[OW:IW] + (p[0] ? {1'b0, a_r} : '0);
        p_next  = {sum, p[IW-1:0]} >> 1;
        add_res = OW'(a_in) + OW'(b_in);
        sub_res = OW'(a_in) - OW'(b_in);
    end

    assign busy = state != IDLE;
    assign done = state == DONE;
    assign ldo  = done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_r    <= '0;
            p      <= '0;
            count  <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    case (op)
                        2'b00: begin
                            result <= add_res;
                            carry  <= add_res[IW];
                            zero   <= add_res == '0;
                            state  <= DONE;
                        end
                        2'b01: begin
                            result <= sub_res;
                            carry  <= a_in < b_in;
                            zero   <= sub_res == '0;
                            state  <= DONE;
                        end
                        2'b10: begin
                            a_r   <= a_in;
                            p     <= {{(IW + 1){1'b0}}, b_in};
                            count <= '0;
                            state <= MUL;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                MUL: begin
                    p     <= p_next;
                    count <= count + CW'(1);
                    if (count == CW'(IW - 1)) begin
                        result <= p_next[OW-1:0];
                        carry  <= 1'b0;
                        zero   <= p_next[OW-1:0] == '0;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checks of alu_sequencer against an
// arithmetic reference model.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic       busy, done, ldo, carry, zero, err;
    logic [7:0] result;
    int total = 0;
    int bad = 0;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .ldo(ldo), .result(result), .carry(carry),
        .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_res(input logic [1:0] o, input int a, input int b);
        return o == 2'b00 ? a + b : o == 2'b01 ? (a - b + 256) % 256 : a * b;
    endfunction

    function automatic logic exp_carry(input logic [1:0] o, input int a, input int b);
        return o == 2'b00 ? (a + b) > 15 : o == 2'b01 ? a < b : 1'b0;
    endfunction

    // Issue one op and observe the completion; lat=0 means no done within the bound.
    task automatic run_op(input logic [1:0] o, input int a, input int b, output int lat,
                          output logic [7:0] res, output logic c, output logic z,
                          output logic l, output logic busy_all);
        logic got;
        a_in = 4'(a); b_in = 4'(b); op = o; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; got = 1'b0; busy_all = 1'b1; res = 'x; c = 'x; z = 'x; l = 'x;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (!busy) busy_all = 1'b0;
            if (done) begin
                got = 1'b1; lat = i; res = result; c = carry; z = zero; l = ldo;
            end else tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++;
        if ({busy, done, ldo, err, carry, zero, result} !== 14'd0) begin
            bad++;
            $display("FAIL reset: got %b required 0", {busy, done, ldo, err, carry, zero, result});
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        int lat; logic [7:0] r; logic c, z, l, b;
        int vec [6][3] = '{'{0, 9, 8}, '{1, 3, 5}, '{1, 7, 7}, '{2, 15, 15}, '{2, 0, 13}, '{0, 1, 1}};
        for (int k = 0; k < 6; k++) begin
            logic [1:0] o;
            int el;
            o = 2'(vec[k][0]);
            el = o == 2'b10 ? 5 : 1;
            run_op(o, vec[k][1], vec[k][2], lat, r, c, z, l, b);
            total++;
            if (lat !== el || r !== 8'(exp_res(o, vec[k][1], vec[k][2])) ||
                c !== exp_carry(o, vec[k][1], vec[k][2]) || z !== (r == 0) || l !== 1'b1 || b !== 1'b1) begin
                bad++;
                $display("FAIL directed%0d: lat=%0d res=%h c=%b z=%b ldo=%b busy=%b required lat=%0d res=%h c=%b",
                         k, lat, r, c, z, l, b, el, 8'(exp_res(o, vec[k][1], vec[k][2])),
                         exp_carry(o, vec[k][1], vec[k][2]));
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: busy=%b required 0", busy);
        end
    endtask

    task automatic test_ignore_start();
        logic seen;
        a_in = 4'd6; b_in = 4'd7; op = 2'b10; start = 1'b1;
        tick();
        start = 1'b0; a_in = 4'd3; b_in = 4'd9;
        tick();
        start = 1'b1; op = 2'b00;
        tick();
        start = 1'b0; seen = 1'b0;
        for (int i = 3; i < 5; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        total++;
        if (seen || done !== 1'b1 || result !== 8'h2A || carry !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start: early=%b done=%b res=%h required done=1 res=2a", seen, done, result);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int lat; logic [7:0] r; logic c, z, l, b;
        a_in = 4'd12; b_in = 4'd11; op = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b res=%h required 0 0 00", busy, done, result);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_nodone: done=%b required 0", done);
            end
            tick();
        end
        run_op(2'b00, 1, 1, lat, r, c, z, l, b);
        total++;
        if (lat !== 1 || r !== 8'h02 || c !== 1'b0 || z !== 1'b0) begin
            bad++;
            $display("FAIL fresh_add: lat=%0d res=%h required lat=1 res=02", lat, r);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] prior;
        prior = result;
        a_in = 4'd5; b_in = 4'd5; op = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err !== 1'b1 || done !== 1'b0 || ldo !== 1'b0 || busy !== 1'b0 || result !== prior) begin
            bad++;
            $display("FAIL illegal: err=%b done=%b ldo=%b busy=%b res=%h required 1 0 0 0 %h",
                     err, done, ldo, busy, result, prior);
        end
        tick();
        total++;
        if (err !== 1'b0 || result !== prior) begin
            bad++;
            $display("FAIL illegal_pulse: err=%b res=%h required 0 %h", err, result, prior);
        end
    endtask

    task automatic test_exhaustive_mul();
        int lat, errs; logic [7:0] r; logic c, z, l, b;
        errs = 0;
        for (int a = 0; a < 16; a++)
            for (int bb = 0; bb < 16; bb++) begin
                run_op(2'b10, a, bb, lat, r, c, z, l, b);
                if (lat !== 5 || r !== 8'(a * bb) || c !== 1'b0 || z !== (a * bb == 0)) begin
                    errs++;
                    if (errs < 5)
                        $display("FAIL mul %0d*%0d: lat=%0d res=%h required lat=5 res=%h", a, bb, lat, r, 8'(a * bb));
                end
            end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL exhaustive_mul: errors=%0d required 0", errs);
        end
    endtask

    task automatic test_random();
        int lat; logic [7:0] r; logic c, z, l, b;
        for (int k = 0; k < 40; k++) begin
            logic [1:0] o;
            int a, bb;
            o = 2'($urandom_range(0, 2)); a = $urandom_range(0, 15); bb = $urandom_range(0, 15);
            run_op(o, a, bb, lat, r, c, z, l, b);
            total++;
            if (lat !== (o == 2'b10 ? 5 : 1) || r !== 8'(exp_res(o, a, bb)) || c !== exp_carry(o, a, bb) ||
                z !== (exp_res(o, a, bb) % 256 == 0) || l !== 1'b1) begin
                bad++;
                $display("FAIL random op=%0d a=%0d b=%0d: lat=%0d res=%h c=%b required res=%h c=%b",
                         o, a, bb, lat, r, c, 8'(exp_res(o, a, bb)), exp_carry(o, a, bb));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        a_in = 4'd5; b_in = 4'd6; op = 2'b00; start = 1'b1; n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done) n++;
        end
        start = 1'b0;
        tick();
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL b2b_add: dones=%0d required 4", n);
        end
        op = 2'b10; start = 1'b1; n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done) n++;
        end
        start = 1'b0;
        tick();
        total++;
        if (n !== 2 || result !== 8'd30) begin
            bad++;
            $display("FAIL b2b_mul: dones=%0d res=%h required 2 1e", n, result);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_illegal();
        test_random();
        test_back_to_back();
        test_exhaustive_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
